bank_ctx_manager: RTL

//   Parametrised register-bank selector with nested interrupt contexts. Holds one bank

---
 rtl/bank_pkg.sv | 28 ++
 rtl/bank_ctx_stack.sv | 58 +++++
 rtl/bank_ctx_manager.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// -----------------------------------------------------------------------------
// Package: bank_pkg
// Shared defaults and types for the bank context manager slice.
//   BANK_W_DEF     default width of a bank index
//   DEPTH_DEF      default maximum interrupt nesting depth
//   ENTRY_BANK_DEF default bank loaded on entry / at reset
//   lvl_w()        width of a level counter able to hold 0..depth
//   ctx_op_t       decoded enter/leave event of one cycle
// -----------------------------------------------------------------------------
package bank_pkg;

   localparam int BANK_W_DEF     = 2;
   localparam int DEPTH_DEF      = 4;
   localparam int ENTRY_BANK_DEF = 0;

   // Level counter width for levels 0..depth (at least one bit).
   function automatic int lvl_w(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_ENTER = 2'b01,
      OP_LEAVE = 2'b10,
      OP_BOTH  = 2'b11
   } ctx_op_t;

endpackage : bank_pkg

// File: rtl/bank_ctx_stack.sv
// -----------------------------------------------------------------------------
// Module: bank_ctx_stack
// Register file holding one bank selection per context level 0..DEPTH.
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset, loads ENTRY_BANK everywhere
//   we       in   write enable for the single write port
//   wr_idx   in   level written by the write port
//   wr_data  in   bank value written
//   clr      in   reload level clr_idx with ENTRY_BANK (entry without retain)
//   clr_idx  in   level reloaded by clr
//   rd_idx   in   level read (the level that becomes active at the next edge)
//   rd_data  out  post-update content of rd_idx, i.e. what the entry will hold
//                 after this edge (write/clear bypassed combinationally)
// -----------------------------------------------------------------------------
module bank_ctx_stack
   import bank_pkg::*;
#(
   parameter int BANK_W     = BANK_W_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int LVL_W      = lvl_w(DEPTH),
   parameter int ENTRY_BANK = ENTRY_BANK_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [LVL_W-1:0]  wr_idx,
   input  logic [BANK_W-1:0] wr_data,
   input  logic              clr,
   input  logic [LVL_W-1:0]  clr_idx,
   input  logic [LVL_W-1:0]  rd_idx,
   output logic [BANK_W-1:0] rd_data
);

   localparam logic [BANK_W-1:0] ENTRY_V = BANK_W'(ENTRY_BANK);

   logic [BANK_W-1:0] ctx [DEPTH+1];

   // NOTE: this small array is reset because every level must read back
   // ENTRY_BANK right after reset; large memories are normally left unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= DEPTH; i++) ctx[i] <= ENTRY_V;
      end else begin
         // The top never aims clr and we at the same level in one cycle.
         if (we)  ctx[wr_idx]  <= wr_data;
         if (clr) ctx[clr_idx] <= ENTRY_V;
      end
   end

   // NOTE: rd_data gets its default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      rd_data = ctx[rd_idx];
      if (clr && (clr_idx == rd_idx)) rd_data = ENTRY_V;
      if (we && (wr_idx == rd_idx))   rd_data = wr_data;
   end

endmodule : bank_ctx_stack

// File: rtl/bank_ctx_manager.sv
// -----------------------------------------------------------------------------
// Module: bank_ctx_manager
// Register-bank selector with a stack of nested interrupt contexts. Level 0 is
// normal code, levels 1..DEPTH are nested IRQs; each level owns a bank register.
// Optional feature macro: BANK_PROTECT_EN (level-0 write protection by PROT_MASK).
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   enter      in   IRQ accepted, push one level (pulse)
//   leave      in   return from IRQ, pop one level (pulse)
//   sBank      in   write sAddrBank into the current level's bank register
//   sAddrBank  in   bank value to write
//   bank       out  registered bank of the active level
//   level      out  current nesting level, 0 = normal context
//   inter      out  level != 0 (registered)
//   ovf        out  pulse: enter while already at DEPTH
//   unf        out  pulse: leave while at level 0
//   prot_err   out  pulse: protected write rejected (0 unless BANK_PROTECT_EN)
// -----------------------------------------------------------------------------
module bank_ctx_manager
   import bank_pkg::*;
#(
   parameter int                       BANK_W     = BANK_W_DEF,
   parameter int                       DEPTH      = DEPTH_DEF,
   parameter int                       RETAIN     = 1,
   parameter int                       ENTRY_BANK = ENTRY_BANK_DEF,
   parameter logic [(2**BANK_W)-1:0]   PROT_MASK  = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enter,
   input  logic                          leave,
   input  logic                          sBank,
   input  logic [BANK_W-1:0]             sAddrBank,
   output logic [BANK_W-1:0]             bank,
   output logic [$clog2(DEPTH+1)-1:0]    level,
   output logic                          inter,
   output logic                          ovf,
   output logic                          unf,
   output logic                          prot_err
);

   localparam int                LVL_W   = $clog2(DEPTH + 1);
   localparam logic [LVL_W-1:0]  MAX_LVL = LVL_W'(DEPTH);
   localparam logic [BANK_W-1:0] ENTRY_V = BANK_W'(ENTRY_BANK);

   ctx_op_t           op;
   logic [LVL_W-1:0]  next_level;
   logic              ovf_d;
   logic              unf_d;
   logic              clr;
   logic              prot_rej;
   logic              wr_en;
   logic [BANK_W-1:0] rd_bank;

   // ---------------------------------------------------------------- events
   always_comb begin
      case ({leave, enter})
         2'b01:   op = OP_ENTER;
         2'b10:   op = OP_LEAVE;
         2'b11:   op = OP_BOTH;
         default: op = OP_NONE;
      endcase
   end

   // Simultaneous enter and leave cancel out: no level move, no flags, no reload.
   always_comb begin
      next_level = level;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      clr        = 1'b0;
      case (op)
         OP_ENTER: begin
            if (level == MAX_LVL) begin
               ovf_d = 1'b1;
            end else begin
               next_level = level + LVL_W'(1);
               clr        = (RETAIN == 0);
            end
         end
         OP_LEAVE: begin
            if (level == '0) unf_d = 1'b1;
            else             next_level = level - LVL_W'(1);
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------ protection
`ifdef BANK_PROTECT_EN
   assign prot_rej = sBank && (level == '0) && PROT_MASK[sAddrBank];
`else
   logic unused_prot_mask;
   assign unused_prot_mask = ^PROT_MASK;
   assign prot_rej         = 1'b0;
`endif

   // The write always targets the pre-event level; the read looks at the
   // post-event level with this cycle's write/reload already folded in.
   assign wr_en = sBank && !prot_rej;

   bank_ctx_stack #(
      .BANK_W     (BANK_W),
      .DEPTH      (DEPTH),
      .LVL_W      (LVL_W),
      .ENTRY_BANK (ENTRY_BANK)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en),
      .wr_idx  (level),
      .wr_data (sAddrBank),
      .clr     (clr),
      .clr_idx (next_level),
      .rd_idx  (next_level),
      .rd_data (rd_bank)
   );

   // -------------------------------------------------------- output register
   // NOTE: state registers use non-blocking assignment so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level    <= '0;
         bank     <= ENTRY_V;
         inter    <= 1'b0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
         prot_err <= 1'b0;
      end else begin
         level    <= next_level;
         bank     <= rd_bank;
         inter    <= (next_level != '0);
         ovf      <= ovf_d;
         unf      <= unf_d;
         prot_err <= prot_rej;
      end
   end

endmodule : bank_ctx_manager
